// File: rtl/vga_pkg.sv
// Shared types for the VGA key-driven pattern generator: display modes,
// keyboard scancodes and the colour-bar table.
package vga_pkg;

  typedef enum logic [2:0] {
    SOLID_W,
    SOLID_R,
    SOLID_G,
    SOLID_B,
    BARS,
    CHECK
  } mode_t;

  localparam logic [7:0] KEY_RED   = 8'h80;
  localparam logic [7:0] KEY_GREEN = 8'h90;
  localparam logic [7:0] KEY_BLUE  = 8'h91;
  localparam logic [7:0] KEY_WHITE = 8'h92;
  localparam logic [7:0] KEY_BARS  = 8'h93;
  localparam logic [7:0] KEY_CHECK = 8'h94;

  typedef struct packed {
    logic  ok;
    mode_t mode;
  } key_dec_t;

  // Bar colours as {r,g,b} on/off flags, entry 0 is the leftmost bar:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic key_dec_t key_to_mode(input logic [7:0] code);
    key_dec_t r;
    r.ok   = 1'b1;
    r.mode = SOLID_W;
    case (code)
      KEY_WHITE: r.mode = SOLID_W;
      KEY_RED:   r.mode = SOLID_R;
      KEY_GREEN: r.mode = SOLID_G;
      KEY_BLUE:  r.mode = SOLID_B;
      KEY_BARS:  r.mode = BARS;
      KEY_CHECK: r.mode = CHECK;
      default:   r.ok   = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, horizontal/vertical counters and raw sync/visible
// decode for the pattern generator.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 11,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 31,
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP,
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP,
  localparam int HW     = $clog2(H_TOT),
  localparam int VW     = $clog2(V_TOT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          pen,
  output logic          visible,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          last_pixel
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [HW-1:0] HS_LO  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_HI  = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_LO  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_HI  = VW'(V_VIS + V_FP + V_SYNC - 1);

  generate
    if (CLK_DIV == 1) begin : g_no_div
      assign pen = 1'b1;
    end else begin : g_div
      logic [DW-1:0] div;

      always_ff @(posedge clk) begin
        if (rst) begin
          div <= '0;
        end else if (div == DW'(CLK_DIV - 1)) begin
          div <= '0;
        end else begin
          div <= div + 1'b1;
        end
      end

      assign pen = (div == DW'(CLK_DIV - 1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (pen) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_comb begin
    visible    = (h < HW'(H_VIS)) && (v < VW'(V_VIS));
    hs_raw     = (h >= HS_LO) && (h <= HS_HI);
    vs_raw     = (v >= VS_LO) && (v <= VS_HI);
    last_pixel = (h == H_LAST) && (v == V_LAST);
  end

endmodule

// File: rtl/vga_key_pattern_gen.sv
// VGA test-pattern generator; keyboard scancodes pick the pattern, and the
// choice is applied only at frame boundaries so a frame never tears.
module vga_key_pattern_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_VIS    = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_VIS    = 480,
  parameter int   V_FP     = 11,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 31,
  parameter logic SYNC_ACT = 1'b0,
  parameter int   COLOR_W  = 4,
  parameter int   CHK_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         scancode,
  input  logic               valid,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               de,
  output logic               frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int BAR_W = (H_VIS >= 8) ? H_VIS / 8 : 1;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          pen;
  logic          visible;
  logic          hs_raw;
  logic          vs_raw;
  logic          last_pixel;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .h          (h),
    .v          (v),
    .pen        (pen),
    .visible    (visible),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .last_pixel (last_pixel)
  );

  mode_t    pending_mode;
  mode_t    active_mode;
  key_dec_t key_dec;

  always_comb key_dec = key_to_mode(scancode);

  // On a commit cycle that also carries a key, active takes the old pending
  // value; the new key waits for the next frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_mode <= SOLID_W;
      active_mode  <= SOLID_W;
    end else begin
      if (valid && key_dec.ok) begin
        pending_mode <= key_dec.mode;
      end
      if (pen && last_pixel) begin
        active_mode <= pending_mode;
      end
    end
  end

  logic [HW-1:0] bar_q;
  logic [2:0]    bar_idx;
  logic [2:0]    pat_rgb;

  always_comb begin
    pat_rgb = 3'b000;
    bar_q   = h / HW'(BAR_W);
    bar_idx = (bar_q > HW'(7)) ? 3'd7 : bar_q[2:0];
    case (active_mode)
      SOLID_W: pat_rgb = 3'b111;
      SOLID_R: pat_rgb = 3'b100;
      SOLID_G: pat_rgb = 3'b010;
      SOLID_B: pat_rgb = 3'b001;
      BARS:    pat_rgb = BAR_RGB[bar_idx];
      CHECK:   pat_rgb = (h[CHK_LOG2] ^ v[CHK_LOG2]) ? 3'b000 : 3'b111;
      default: pat_rgb = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
    end else begin
      frame_start <= 1'b0;
      if (pen) begin
        red         <= {COLOR_W{pat_rgb[2] & visible}};
        green       <= {COLOR_W{pat_rgb[1] & visible}};
        blue        <= {COLOR_W{pat_rgb[0] & visible}};
        de          <= visible;
        frame_start <= (h == '0) && (v == '0);
        hsync       <= hs_raw ? SYNC_ACT : ~SYNC_ACT;
        vsync       <= vs_raw ? SYNC_ACT : ~SYNC_ACT;
      end
    end
  end

endmodule

// File: tb/tb_vga_key_pattern_gen.sv
// Directed bench for vga_key_pattern_gen on a reduced 48x22 raster so that
// several whole frames fit in a short run.
module tb_vga_key_pattern_gen;

  localparam int CD  = 2;
  localparam int HV  = 32;
  localparam int HF  = 4;
  localparam int HS  = 6;
  localparam int HB  = 6;
  localparam int VV  = 16;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int CW  = 4;
  localparam int HT  = HV + HF + HS + HB;
  localparam int VT  = VV + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * CD;

  logic          clk;
  logic          rst;
  logic [7:0]    scancode;
  logic          valid;
  logic          hsync;
  logic          vsync;
  logic [CW-1:0] red;
  logic [CW-1:0] green;
  logic [CW-1:0] blue;
  logic          de;
  logic          frame_start;

  vga_key_pattern_gen #(
    .CLK_DIV  (CD),
    .H_VIS    (HV),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_VIS    (VV),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .SYNC_ACT (1'b0),
    .COLOR_W  (CW),
    .CHK_LOG2 (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scancode    (scancode),
    .valid       (valid),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .de          (de),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int pix_clk;
  int last_period;
  bit synced;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to the next falling edge and track which pixel is on the outputs,
  // using frame_start as the only reference point.
  task automatic step();
    @(negedge clk);
    if (frame_start) begin
      if (synced) last_period = pix_clk + 1;
      pix_clk = 0;
      synced  = 1'b1;
    end else begin
      pix_clk++;
    end
  endtask

  task automatic wait_pix(input int th, input int tv, input string tag);
    bit found = 1'b0;
    for (int n = 0; n < 2 * FRAME_CLK && !found; n++) begin
      step();
      if (synced && (pix_clk % CD) == 0 && (pix_clk / CD) % HT == th && (pix_clk / CD) / HT == tv)
        found = 1'b1;
    end
    check({tag, "_reach"}, found, 1'b1);
  endtask

  task automatic chk_px(input string tag, input logic [11:0] exp_rgb, input logic exp_de);
    check({tag, "_rgb"}, {red, green, blue}, exp_rgb);
    check({tag, "_de"}, de, exp_de);
  endtask

  task automatic send_key(input logic [7:0] code);
    scancode = code;
    valid    = 1'b1;
    step();
    valid    = 1'b0;
    scancode = 8'h00;
  endtask

  task automatic release_and_sync(input string tag);
    int n = 0;
    rst    = 1'b0;
    synced = 1'b0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 16);
    check({tag, "_fs_latency"}, n, 2);
  endtask

  initial begin
    int lows;
    n_chk = 0; n_pass = 0; pix_clk = 0; last_period = 0; synced = 1'b0;
    rst = 1'b1; valid = 1'b0; scancode = 8'h00;
    repeat (3) step();
    check("rst_rgb", {red, green, blue}, 12'h000);
    check("rst_de", de, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    check("rst_syncs", {hsync, vsync}, 2'b11);

    // frame A: solid white from reset
    release_and_sync("init");
    chk_px("a_0_0", 12'hFFF, 1'b1);
    step();
    check("fs_width", frame_start, 1'b0);
    wait_pix(31, 0, "a_31_0");  chk_px("a_31_0", 12'hFFF, 1'b1);
    wait_pix(32, 0, "a_32_0");  chk_px("a_32_0", 12'h000, 1'b0);
    wait_pix(35, 0, "a_35_0");  check("hs_before", hsync, 1'b1);
    lows = 0;
    for (int i = 0; i < HT * CD; i++) begin
      if (!hsync) lows++;
      step();
    end
    check("hs_low_clks", lows, HS * CD);
    wait_pix(36, 1, "a_36_1");  check("hs_first", hsync, 1'b0);
    wait_pix(41, 1, "a_41_1");  check("hs_last", hsync, 1'b0);
    wait_pix(42, 1, "a_42_1");  check("hs_after", hsync, 1'b1);
    wait_pix(0, 3, "a_0_3");
    send_key(8'h80);
    wait_pix(10, 10, "a_10_10"); chk_px("a_10_10", 12'hFFF, 1'b1);
    wait_pix(31, 15, "a_31_15"); chk_px("a_31_15", 12'hFFF, 1'b1);
    wait_pix(0, 16, "a_0_16");   chk_px("a_0_16", 12'h000, 1'b0);
    wait_pix(0, 17, "a_0_17");   check("vs_before", vsync, 1'b1);
    wait_pix(0, 18, "a_0_18");   check("vs_first", vsync, 1'b0);
    wait_pix(47, 19, "a_47_19"); check("vs_last", vsync, 1'b0);
    wait_pix(0, 20, "a_0_20");   check("vs_after", vsync, 1'b1);

    // frame B: red; green key lands exactly on the commit cycle
    wait_pix(0, 0, "b_0_0");     chk_px("b_0_0", 12'hF00, 1'b1);
    check("frame_period", last_period, FRAME_CLK);
    wait_pix(46, 21, "b_46_21");
    step();
    send_key(8'h90);

    // frame C: still red; unknown key and an unqualified code are ignored
    wait_pix(0, 0, "c_0_0");     chk_px("c_0_0", 12'hF00, 1'b1);
    wait_pix(0, 3, "c_0_3");
    send_key(8'h55);
    scancode = 8'h91;
    repeat (4) step();
    scancode = 8'h00;

    // frame D: green; request bars
    wait_pix(0, 0, "d_0_0");     chk_px("d_0_0", 12'h0F0, 1'b1);
    wait_pix(0, 3, "d_0_3");
    send_key(8'h93);

    // frame E: colour bars, 4 pixels wide; request checkerboard
    wait_pix(0, 0, "e_0_0");     chk_px("e_0_0", 12'hFFF, 1'b1);
    wait_pix(3, 0, "e_3_0");     chk_px("e_3_0", 12'hFFF, 1'b1);
    wait_pix(4, 0, "e_4_0");     chk_px("e_4_0", 12'hFF0, 1'b1);
    wait_pix(12, 0, "e_12_0");   chk_px("e_12_0", 12'h0F0, 1'b1);
    wait_pix(28, 0, "e_28_0");   chk_px("e_28_0", 12'h000, 1'b1);
    wait_pix(8, 1, "e_8_1");     chk_px("e_8_1", 12'h0FF, 1'b1);
    wait_pix(16, 1, "e_16_1");   chk_px("e_16_1", 12'hF0F, 1'b1);
    wait_pix(0, 5, "e_0_5");
    send_key(8'h94);

    // frame F: 4x4 checkerboard; then a pending key and a mid-line reset
    wait_pix(0, 0, "f_0_0");     chk_px("f_0_0", 12'hFFF, 1'b1);
    wait_pix(4, 0, "f_4_0");     chk_px("f_4_0", 12'h000, 1'b1);
    wait_pix(0, 4, "f_0_4");     chk_px("f_0_4", 12'h000, 1'b1);
    wait_pix(4, 4, "f_4_4");     chk_px("f_4_4", 12'hFFF, 1'b1);
    wait_pix(0, 6, "f_0_6");
    send_key(8'h91);
    wait_pix(10, 6, "f_10_6");
    rst = 1'b1;
    repeat (3) step();
    check("mid_rst_rgb", {red, green, blue}, 12'h000);
    check("mid_rst_hs", hsync, 1'b1);
    release_and_sync("mid");
    check("mid_fs", frame_start, 1'b1);
    chk_px("mid_0_0", 12'hFFF, 1'b1);
    check("mid_hs", hsync, 1'b1);
    wait_pix(0, 0, "g_0_0");     chk_px("g_0_0", 12'hFFF, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
